// File: rtl/mem_pkg.sv
// Shared types and widths for the mem_responder slice.
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t RESP = 2'd2;
    localparam state_t DONE = 2'd3;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable latency down-counter for mem_responder.
module mem_lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] init,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= init;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    // Flags the edge at which the count lands on zero, so the FSM leaves BUSY in step.
    assign zero = (cnt <= W'(1));

endmodule

// File: rtl/mem_responder.sv
// Latency-programmable word memory responder for a CPU load/store port.
// Per-byte write strobes (Byte_en port) exist only when MEM_BYTE_STROBE_EN is defined.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [WORD_W-1:0] Address,
    input  logic [WORD_W-1:0] Write_data,
`ifdef MEM_BYTE_STROBE_EN
    input  logic [LANES-1:0]  Byte_en,
`endif
    output logic [WORD_W-1:0] Read_data,
    output logic              Mem_ready,
    output logic              Mem_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t              state, nstate;
    logic                cnt_load, cnt_en, cnt_zero;
    logic                rd_q, wr_q, err_q;
    logic [AW-1:0]       idx_q;
    logic [WORD_W-1:0]   wdata_q;
    logic [LANES-1:0]    be_q, be_in;
    logic                err_in, cur_rd, cur_err;
    logic [AW-1:0]       cur_idx;
    logic [WORD_W-1:0]   mem [DEPTH];

`ifdef MEM_BYTE_STROBE_EN
    assign be_in = Byte_en;
`else
    assign be_in = '1;
`endif

    assign err_in = (MemRead & MemWrite) | (|Address[1:0])
                  | ({2'b00, Address[WORD_W-1:2]} >= 32'(DEPTH));

    // With LATENCY=1 RESP is entered on the accepting edge, so use live inputs there.
    assign cur_rd  = (state == IDLE) ? MemRead           : rd_q;
    assign cur_err = (state == IDLE) ? err_in            : err_q;
    assign cur_idx = (state == IDLE) ? Address[AW+1:2]   : idx_q;

    mem_lat_counter #(.W(4)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .en    (cnt_en),
        .init  (4'(LATENCY - 1)),
        .zero  (cnt_zero)
    );

    always_comb begin
        nstate   = state;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state)
            IDLE: begin
                if (MemRead | MemWrite) begin
                    cnt_load = 1'b1;
                    nstate   = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_en = 1'b1;
                if (cnt_zero) nstate = RESP;
            end
            RESP:    nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            Read_data <= '0;
        end else begin
            state <= nstate;
            if (state == IDLE && (MemRead | MemWrite)) begin
                rd_q    <= MemRead;
                wr_q    <= MemWrite;
                err_q   <= err_in;
                idx_q   <= Address[AW+1:2];
                wdata_q <= Write_data;
                be_q    <= be_in;
            end
            if (nstate == RESP && cur_rd) begin
                Read_data <= cur_err ? '0 : mem[cur_idx];
            end
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (state == RESP && wr_q && !err_q) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign Mem_ready = (state == RESP);
    assign Mem_err   = (state == RESP) & err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder (DEPTH=256, LATENCY=2); byte-strobe cases need MEM_BYTE_STROBE_EN.
module tb_mem_responder;

    localparam int unsigned LAT = 2;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Address = '0;
    logic [31:0] Write_data = '0;
`ifdef MEM_BYTE_STROBE_EN
    logic [3:0]  Byte_en = 4'hF;
`endif
    logic [31:0] Read_data;
    logic        Mem_ready;
    logic        Mem_err;

    int unsigned cyc = 0;
    int unsigned idle_at = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_rd = '0;
    exp_t        sb[$];
    exp_t        mon_e;

    mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .Write_data (Write_data),
`ifdef MEM_BYTE_STROBE_EN
        .Byte_en    (Byte_en),
`endif
        .Read_data  (Read_data),
        .Mem_ready  (Mem_ready),
        .Mem_err    (Mem_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every Mem_ready pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (Mem_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: Mem_ready=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("ready_cycle", cyc, mon_e.due);
                chk("mem_err", {31'b0, Mem_err}, {31'b0, mon_e.err});
                chk("read_data", Read_data, mon_e.data);
            end
        end
    end

    task automatic wait_ready();
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Mem_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: no Mem_ready within 40 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic wait_idle();
        @(negedge clk);
        while (cyc < idle_at) @(negedge clk);
    endtask

    // Pulse is visible in the cycle ending LAT edges after the accepting edge;
    // RESP, DONE, then IDLE must pass before the next acceptance.
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        wait_idle();
        MemRead    = rd;
        MemWrite   = wr;
        Address    = addr;
        Write_data = wdata;
        e.due  = cyc + 1 + LAT - 1;
        e.data = exp_data;
        e.err  = exp_err;
        sb.push_back(e);
        wait_ready();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        idle_at  = e.due + 2;
    endtask

    task automatic rd_t(input logic [31:0] addr, input logic [31:0] word, input logic err);
        last_rd = err ? 32'h0 : word;
        txn(1'b1, 1'b0, addr, 32'h0, last_rd, err);
    endtask

    task automatic wr_t(input logic [31:0] addr, input logic [31:0] data, input logic err);
        txn(1'b0, 1'b1, addr, data, last_rd, err);
    endtask

    task automatic held_read(input logic [31:0] addr, input logic [31:0] word);
        exp_t e;
        wait_idle();
        MemRead = 1'b1;
        Address = addr;
        for (int unsigned k = 0; k < 3; k++) begin
            e.due  = cyc + 1 + LAT - 1 + k * (LAT + 2);
            e.data = word;
            e.err  = 1'b0;
            sb.push_back(e);
        end
        for (int k = 0; k < 3; k++) wait_ready();
        MemRead = 1'b0;
        last_rd = word;
        idle_at = e.due + 2;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        #2;
        chk("reset_ready", {31'b0, Mem_ready}, 32'h0);
        chk("reset_err", {31'b0, Mem_err}, 32'h0);
        chk("reset_rdata", Read_data, 32'h0);
        repeat (2) @(negedge clk);
        reset   = 1'b1;
        idle_at = cyc;

        wr_t(32'h10, 32'hDEADBEEF, 1'b0);
        rd_t(32'h10, 32'hDEADBEEF, 1'b0);
        rd_t(32'h13, 32'h0, 1'b1);
        rd_t(32'h10, 32'hDEADBEEF, 1'b0);
        rd_t(32'h400, 32'h0, 1'b1);

        wr_t(32'h20, 32'h00001234, 1'b0);
        txn(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0, 1'b1);
        last_rd = 32'h0;
        rd_t(32'h20, 32'h00001234, 1'b0);

        wr_t(32'h30, 32'h00000055, 1'b0);
        rd_t(32'h30, 32'h00000055, 1'b0);

        // Reset lands while the write of 0xFFFF0000 is in BUSY.
        wait_idle();
        MemWrite   = 1'b1;
        Address    = 32'h30;
        Write_data = 32'hFFFF0000;
        @(negedge clk);
        reset    = 1'b0;
        MemWrite = 1'b0;
        #1;
        chk("abort_ready", {31'b0, Mem_ready}, 32'h0);
        chk("abort_err", {31'b0, Mem_err}, 32'h0);
        chk("abort_rdata", Read_data, 32'h0);
        repeat (3) @(negedge clk);
        reset   = 1'b1;
        last_rd = 32'h0;
        idle_at = cyc;
        rd_t(32'h30, 32'h00000055, 1'b0);

        wr_t(32'h3FC, 32'hA5A50F0F, 1'b0);
        rd_t(32'h3FC, 32'hA5A50F0F, 1'b0);
        wr_t(32'h400, 32'h12345678, 1'b1);

        held_read(32'h10, 32'hDEADBEEF);

`ifdef MEM_BYTE_STROBE_EN
        wr_t(32'h40, 32'h11223344, 1'b0);
        Byte_en = 4'b0101;
        wr_t(32'h40, 32'hAABBCCDD, 1'b0);
        Byte_en = 4'hF;
        rd_t(32'h40, 32'h11BB33DD, 1'b0);
        Byte_en = 4'b0000;
        wr_t(32'h40, 32'hFFFFFFFF, 1'b0);
        Byte_en = 4'hF;
        rd_t(32'h40, 32'h11BB33DD, 1'b0);
`endif

        repeat (6) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
